// File: rtl/count_seg7_scan.sv
// -----------------------------------------------------------------------------
// count_seg7_scan
//   Two-digit, time-multiplexed seven-segment driver for the up/down counter.
//   Digit 0 shows count_up in hex and digit 1 shows count_down in hex. Both
//   counts are snapshotted together at the start of each scan frame, so a
//   displayed frame never mixes old and new values.
//
//   Optional feature macro: SEG7_WRAP_BLINK_EN
//     When defined, a snapshot of count_up going F -> 0 blanks the up digit
//     for BLINK_SCANS frames. The anode timing is unchanged while blanked.
//
// Parameters
//   REFRESH_DIV    clk cycles each digit stays lit (>= 2)
//   SEG_ACTIVE_LOW 1 = seg/an active-low (common anode), 0 = active-high
//   BLINK_SCANS    frames the up digit stays blank after a wrap
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   enable     1 = scanning, 0 = display blanked (FSM held in IDLE)
//   count_up   4-bit up-counter value
//   count_down 4-bit down-counter value
//   seg        registered segments {g,f,e,d,c,b,a}
//   an         registered digit enables, an[0] = up digit, an[1] = down digit
//   digit_sel  registered, 0 = up digit lit, 1 = down digit lit (0 in IDLE)
// -----------------------------------------------------------------------------
module count_seg7_scan #(
    parameter int REFRESH_DIV    = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int BLINK_SCANS    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] count_up,
    input  logic [3:0] count_down,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       digit_sel
);

    localparam int          PW       = $clog2(REFRESH_DIV);
    localparam int          BW       = (BLINK_SCANS < 1) ? 1 : $clog2(BLINK_SCANS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]  AN_OFF   = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;
    localparam logic [1:0]  AN_UP    = SEG_ACTIVE_LOW ? 2'b10 : 2'b01;
    localparam logic [1:0]  AN_DOWN  = SEG_ACTIVE_LOW ? 2'b01 : 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHOW_UP   = 2'd1,
        SHOW_DOWN = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] prescaler, prescaler_nxt;
    logic [3:0]    snap_up, snap_up_nxt;
    logic [3:0]    snap_down, snap_down_nxt;
    logic          frame_start;
    logic [BW-1:0] blink_nxt;
    logic [6:0]    seg_nxt;
    logic [1:0]    an_nxt;
    logic          digit_sel_nxt;

    // Active-high hex patterns, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    function automatic logic [6:0] seg_pol(input logic [6:0] p);
        return SEG_ACTIVE_LOW ? ~p : p;
    endfunction

    // Next-state, prescaler and snapshot logic.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      state_nxt = SHOW_UP;
                SHOW_UP:   if (prescaler == PRE_LAST) state_nxt = SHOW_DOWN;
                SHOW_DOWN: if (prescaler == PRE_LAST) state_nxt = SHOW_UP;
                default:   state_nxt = IDLE;
            endcase
        end

        // Entering SHOW_UP (from IDLE or on a frame wrap) starts a new frame.
        frame_start = (state_nxt == SHOW_UP) && (state != SHOW_UP);

        if ((state_nxt != state) || (state_nxt == IDLE))
            prescaler_nxt = '0;
        else
            prescaler_nxt = prescaler + PW'(1);

        snap_up_nxt   = frame_start ? count_up   : snap_up;
        snap_down_nxt = frame_start ? count_down : snap_down;
    end

    // Outputs are decoded from the next state and next snapshot so the
    // registered display changes on the same edge as the FSM.
    always_comb begin
        seg_nxt       = SEG_OFF;
        an_nxt        = AN_OFF;
        digit_sel_nxt = 1'b0;
        case (state_nxt)
            SHOW_UP: begin
                an_nxt = AN_UP;
                if (blink_nxt == '0)
                    seg_nxt = seg_pol(hex7(snap_up_nxt));
            end
            SHOW_DOWN: begin
                an_nxt        = AN_DOWN;
                seg_nxt       = seg_pol(hex7(snap_down_nxt));
                digit_sel_nxt = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef SEG7_WRAP_BLINK_EN
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_SCANS);

    logic [3:0]    prev_up;
    logic [BW-1:0] blink_cnt;

    // A wrap at a frame start (re)loads the counter; otherwise it counts
    // down once per frame. Leaving to IDLE forgets any pending blink.
    always_comb begin
        blink_nxt = blink_cnt;
        if (state_nxt == IDLE) begin
            blink_nxt = '0;
        end else if (frame_start) begin
            if ((prev_up == 4'hF) && (count_up == 4'h0))
                blink_nxt = BLINK_LOAD;
            else if (blink_cnt != '0)
                blink_nxt = blink_cnt - BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_up   <= 4'h0;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_nxt;
            if (state_nxt == IDLE)
                prev_up <= 4'h0;
            else if (frame_start)
                prev_up <= count_up;
        end
    end
`else
    assign blink_nxt = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prescaler <= '0;
            snap_up   <= 4'h0;
            snap_down <= 4'h0;
            seg       <= SEG_OFF;
            an        <= AN_OFF;
            digit_sel <= 1'b0;
        end else begin
            state     <= state_nxt;
            prescaler <= prescaler_nxt;
            snap_up   <= snap_up_nxt;
            snap_down <= snap_down_nxt;
            seg       <= seg_nxt;
            an        <= an_nxt;
            digit_sel <= digit_sel_nxt;
        end
    end

endmodule

// File: tb/tb_count_seg7_scan.sv
// -----------------------------------------------------------------------------
// tb_count_seg7_scan
//   Self-checking bench for count_seg7_scan (REFRESH_DIV=4, active-low,
//   BLINK_SCANS=8). A frame-position reference model predicts seg/an/digit_sel
//   every cycle; a vector table and hand sequences pin down the documented
//   scan, snapshot, enable-drop, reset and wrap behaviour.
// -----------------------------------------------------------------------------
module tb_count_seg7_scan;

    localparam int DIV   = 4;
    localparam int BLINK = 8;
`ifdef SEG7_WRAP_BLINK_EN
    localparam int MB = BLINK;
`else
    localparam int MB = 0;
`endif

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] count_up = 4'h0;
    logic [3:0] count_down = 4'h0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       digit_sel;

    int nchk = 0;
    int nerr = 0;

    count_seg7_scan #(
        .REFRESH_DIV(DIV),
        .SEG_ACTIVE_LOW(1'b1),
        .BLINK_SCANS(BLINK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .count_up(count_up),
        .count_down(count_down),
        .seg(seg),
        .an(an),
        .digit_sel(digit_sel)
    );

    always #5 if (clk_en) clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] hex [16];
    int         m_run;    // edges since scanning began
    int         m_since;  // frames since last wrap (saturating)
    logic [3:0] m_prev, m_su, m_sd;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_dsel;

    function automatic void model_reset();
        m_run = 0; m_since = 1000; m_prev = 4'h0; m_su = 4'h0; m_sd = 4'h0;
        e_seg = 7'h7F; e_an = 2'b11; e_dsel = 1'b0;
    endfunction

    function automatic void model_edge(input logic en, input logic [3:0] u, input logic [3:0] d);
        int p;
        if (!en) begin
            model_reset();
        end else begin
            p = m_run % (2 * DIV);
            m_run++;
            if (p == 0) begin
                if (m_prev == 4'hF && u == 4'h0) m_since = 0;
                else if (m_since < 1000) m_since++;
                m_prev = u; m_su = u; m_sd = d;
            end
            if (p < DIV) begin
                e_an = 2'b10; e_dsel = 1'b0;
                e_seg = (m_since < MB) ? 7'h7F : ~hex[m_su];
            end else begin
                e_an = 2'b01; e_dsel = 1'b1;
                e_seg = ~hex[m_sd];
            end
        end
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got {seg,an,dsel}=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, take one edge, compare against the model #1 later.
    task automatic cyc(input logic en, input logic [3:0] u, input logic [3:0] d);
        enable = en; count_up = u; count_down = d;
        @(posedge clk);
        model_edge(en, u, d);
        #1;
        check("model", {seg, an, digit_sel}, {e_seg, e_an, e_dsel});
    endtask

    // Assert rst between edges, confirm blanking before and after an edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_async", {seg, an, digit_sel}, {7'h7F, 2'b11, 1'b0});
        @(posedge clk);
        #1;
        check("rst_hold", {seg, an, digit_sel}, {7'h7F, 2'b11, 1'b0});
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       en;
        logic [3:0] up;
        logic [3:0] dn;
        int         n;
        logic [6:0] seg;
        logic [1:0] an;
        logic       dsel;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [3:0] u, d;
        logic       en;

        hex = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        // basic scan 3/C, snapshot change during down slot, enable drop, re-enable
        tbl[0] = '{1'b1, 4'h3, 4'hC, 4, 7'h30, 2'b10, 1'b0};
        tbl[1] = '{1'b1, 4'h3, 4'hC, 4, 7'h46, 2'b01, 1'b1};
        tbl[2] = '{1'b1, 4'h3, 4'hC, 4, 7'h30, 2'b10, 1'b0};
        tbl[3] = '{1'b1, 4'h9, 4'hC, 4, 7'h46, 2'b01, 1'b1};
        tbl[4] = '{1'b1, 4'h9, 4'hC, 2, 7'h10, 2'b10, 1'b0};
        tbl[5] = '{1'b0, 4'h9, 4'hC, 2, 7'h7F, 2'b11, 1'b0};
        tbl[6] = '{1'b1, 4'h9, 4'hC, 4, 7'h10, 2'b10, 1'b0};
        tbl[7] = '{1'b1, 4'h9, 4'hC, 1, 7'h46, 2'b01, 1'b1};

        // reset with no clock running
        #2 rst = 1'b1;
        #1;
        check("reset_noclk", {seg, an, digit_sel}, {7'h7F, 2'b11, 1'b0});
        model_reset();
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // table: first row's first edge is the first edge after rst release
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                cyc(tbl[i].en, tbl[i].up, tbl[i].dn);
                check($sformatf("tbl%0d_%0d", i, k), {seg, an, digit_sel},
                      {tbl[i].seg, tbl[i].an, tbl[i].dsel});
            end
        end

        // async reset inside SHOW_DOWN, then release with enable high
        cyc(1'b1, 4'h9, 4'hC);
        cyc(1'b1, 4'h9, 4'hC);
        do_reset();
        cyc(1'b1, 4'h5, 4'hA);
        check("rst_release_up", {seg, an, digit_sel}, {7'h12, 2'b10, 1'b0});
        for (int k = 1; k < DIV; k++) begin
            cyc(1'b1, 4'h5, 4'hA);
            check("rst_release_slot", {1'b0, an}, {1'b0, 2'b10});
        end
        cyc(1'b1, 4'h5, 4'hA);
        check("rst_release_down", {seg, an, digit_sel}, {7'h08, 2'b01, 1'b1});

        // wrap: one frame snapshotting F, then 0 for ten frames
        cyc(1'b0, 4'hF, 4'h5);
        for (int k = 0; k < 2 * DIV; k++) cyc(1'b1, 4'hF, 4'h5);
        for (int f = 0; f < 10; f++) begin
            cyc(1'b1, 4'h0, 4'h5);
            check($sformatf("wrap_f%0d", f), {seg, an, digit_sel},
                  {(f < MB) ? 7'h7F : 7'h40, 2'b10, 1'b0});
            for (int k = 1; k < 2 * DIV; k++) cyc(1'b1, 4'h0, 4'h5);
        end

        // randomized traffic against the model, biased toward F/0 wraps
        for (int n = 0; n < 3000; n++) begin
            en = ($urandom_range(0, 19) != 0);
            case ($urandom_range(0, 3))
                0: u = 4'hF;
                1: u = 4'h0;
                default: u = 4'($urandom_range(0, 15));
            endcase
            d = 4'($urandom_range(0, 15));
            cyc(en, u, d);
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
